// File: rtl/operand_fetch.sv
// operand_fetch: decode / operand-fetch stage in front of the execute stage.
//
// This stage decodes each instruction and drives the register file read
// addresses. It captures the returned operands and tracks in-flight
// destinations in a scoreboard. It stalls on RAW and WAW hazards, and
// presents one decoded instruction per cycle through a valid/ready output
// register.
//
// Optional feature: OPERAND_FETCH_WB_BYPASS_EN
//   When this macro is defined, a retiring writeback is forwarded into the
//   operands. Its scoreboard bit is also ignored by the hazard check in the
//   same cycle, which saves one stall cycle. When the macro is undefined,
//   wb_data is ignored.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_instr upstream handshake and instruction
//   rf_read_Ra/rf_read_Rb      register file read addresses (combinational)
//   rf_data_Ra/rf_data_Rb      register file read data
//   wb_valid/wb_rd/wb_data     retiring register write
//   out_valid/out_ready        downstream handshake
//   out_opcode/out_rd/out_wr_en/out_a/out_b/out_imm  registered decoded fields

module operand_fetch #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_CNT = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic [ADDR_W-1:0] rf_read_Ra,
    output logic [ADDR_W-1:0] rf_read_Rb,
    input  logic [DATA_W-1:0] rf_data_Ra,
    input  logic [DATA_W-1:0] rf_data_Rb,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wr_en,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm
);

    logic [3:0]         opcode;
    logic [ADDR_W-1:0]  rd, ra, rb;
    logic [15:0]        imm;
    logic               wr_en;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  op_a, op_b;

    logic [REG_CNT-1:0] pend;      // bit n set: a write to register n is in flight
    logic [REG_CNT-1:0] clr;       // bit being retired this cycle
    logic [REG_CNT-1:0] set;       // bit being claimed by an accepted instruction
    logic [REG_CNT-1:0] pend_chk;  // scoreboard view used by the hazard check
    logic               stall;
    logic               accept;

    assign opcode  = in_instr[31:28];
    assign rd      = in_instr[24 +: ADDR_W];
    assign ra      = in_instr[20 +: ADDR_W];
    assign rb      = in_instr[16 +: ADDR_W];
    assign imm     = in_instr[15:0];
    assign wr_en   = (opcode[3:2] != 2'b11);
    assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};

    assign rf_read_Ra = ra;
    assign rf_read_Rb = rb;

    always_comb begin
        clr = '0;
        set = '0;
        if (wb_valid) clr[wb_rd] = 1'b1;
        if (accept && wr_en) set[rd] = 1'b1;
    end

`ifdef OPERAND_FETCH_WB_BYPASS_EN
    // The register file write lands one edge later, so forward it here.
    assign op_a     = (wb_valid && wb_rd == ra) ? wb_data : rf_data_Ra;
    assign op_b     = (wb_valid && wb_rd == rb) ? wb_data : rf_data_Rb;
    assign pend_chk = pend & ~clr;
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign op_a     = rf_data_Ra;
    assign op_b     = rf_data_Rb;
    assign pend_chk = pend;
`endif

    assign stall    = in_valid && (pend_chk[ra] || pend_chk[rb] || (wr_en && pend_chk[rd]));
    assign in_ready = !stall && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= '0;
            out_valid  <= 1'b0;
            out_opcode <= '0;
            out_rd     <= '0;
            out_wr_en  <= 1'b0;
            out_a      <= '0;
            out_b      <= '0;
            out_imm    <= '0;
        end else begin
            // Clear first, then set: a same-cycle set of the same bit wins.
            pend <= (pend & ~clr) | set;
            if (accept) begin
                out_valid  <= 1'b1;
                out_opcode <= opcode;
                out_rd     <= rd;
                out_wr_en  <= wr_en;
                out_a      <= op_a;
                out_b      <= op_b;
                out_imm    <= imm_ext;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch.

module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [3:0]  rf_read_Ra, rf_read_Rb;
  logic [31:0] rf_data_Ra, rf_data_Rb;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic [31:0] out_a, out_b, out_imm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .rf_read_Ra (rf_read_Ra),
    .rf_read_Rb (rf_read_Rb),
    .rf_data_Ra (rf_data_Ra),
    .rf_data_Rb (rf_data_Rb),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rd     (out_rd),
    .out_wr_en  (out_wr_en),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_imm    (out_imm)
  );

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    errors++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_instr   = 32'h1500_0000;
    rf_data_Ra = 32'd0;
    rf_data_Rb = 32'd0;
    wb_valid   = 1'b1;
    wb_rd      = 4'd0;
    wb_data    = 32'd0;
    out_ready  = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) fail("rst_out_valid", out_valid, 1'b0);
    checks++; if (dut.pend !== 16'h0000) fail("rst_pend", dut.pend, 16'h0000);
    checks++; if (out_a !== 32'h0) fail("rst_out_a", out_a, 32'h0);
    checks++; if (out_imm !== 32'h0) fail("rst_out_imm", out_imm, 32'h0);

    rst        = 1'b0;
    wb_valid   = 1'b0;
    in_instr   = 32'h1312_FFFE;
    rf_data_Ra = 32'd5;
    rf_data_Rb = 32'd7;
    #1;
    checks++; if (rf_read_Ra !== 4'd1) fail("rd_addr_a", rf_read_Ra, 4'd1);
    checks++; if (rf_read_Rb !== 4'd2) fail("rd_addr_b", rf_read_Rb, 4'd2);
    checks++; if (in_ready !== 1'b1) fail("first_in_ready", in_ready, 1'b1);
    tick();
    checks++; if (out_valid !== 1'b1) fail("first_out_valid", out_valid, 1'b1);
    checks++; if (out_a !== 32'd5) fail("first_out_a", out_a, 32'd5);
    checks++; if (out_b !== 32'd7) fail("first_out_b", out_b, 32'd7);
    checks++; if (out_imm !== 32'hFFFF_FFFE) fail("first_out_imm", out_imm, 32'hFFFF_FFFE);
    checks++; if (out_wr_en !== 1'b1) fail("first_wr_en", out_wr_en, 1'b1);
    checks++; if (out_opcode !== 4'h1) fail("first_opcode", out_opcode, 4'h1);
    checks++; if (out_rd !== 4'd3) fail("first_rd", out_rd, 4'd3);
    checks++; if (dut.pend !== 16'h0008) fail("first_pend", dut.pend, 16'h0008);

    in_instr   = 32'h2530_0000;
    rf_data_Ra = 32'h11;
    rf_data_Rb = 32'h22;
    #1;
    checks++; if (in_ready !== 1'b0) fail("raw_stall", in_ready, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b0) fail("raw_drain_valid", out_valid, 1'b0);
    checks++; if (in_ready !== 1'b0) fail("raw_still_stall", in_ready, 1'b0);
    wb_valid = 1'b1;
    wb_rd    = 4'd3;
    wb_data  = 32'h99;
    #1;
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    checks++; if (in_ready !== 1'b1) fail("raw_wb_release", in_ready, 1'b1);
    tick();
    wb_valid   = 1'b0;
    in_valid   = 1'b0;
    rf_data_Ra = 32'h99;
    #1;
    checks++; if (out_valid !== 1'b1) fail("raw_bypass_valid", out_valid, 1'b1);
    checks++; if (out_a !== 32'h99) fail("raw_bypass_a", out_a, 32'h99);
`else
    checks++; if (in_ready !== 1'b0) fail("raw_wb_still_stall", in_ready, 1'b0);
    tick();
    wb_valid   = 1'b0;
    rf_data_Ra = 32'h99;
    #1;
    checks++; if (dut.pend !== 16'h0000) fail("raw_pend_cleared", dut.pend, 16'h0000);
    checks++; if (in_ready !== 1'b1) fail("raw_release", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) fail("raw_out_valid", out_valid, 1'b1);
    checks++; if (out_a !== 32'h99) fail("raw_out_a", out_a, 32'h99);
`endif
    checks++; if (out_rd !== 4'd5) fail("raw_out_rd", out_rd, 4'd5);
    checks++; if (dut.pend !== 16'h0020) fail("raw_pend", dut.pend, 16'h0020);

    in_valid = 1'b1;
    in_instr = 32'hC400_1234;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) fail("nowr_valid", out_valid, 1'b1);
    checks++; if (out_opcode !== 4'hC) fail("nowr_opcode", out_opcode, 4'hC);
    checks++; if (out_wr_en !== 1'b0) fail("nowr_wr_en", out_wr_en, 1'b0);
    checks++; if (out_imm !== 32'h0000_1234) fail("nowr_imm", out_imm, 32'h0000_1234);
    checks++; if (dut.pend !== 16'h0020) fail("nowr_pend", dut.pend, 16'h0020);

    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_instr   = 32'h3700_0005;
    rf_data_Ra = 32'd1;
    rf_data_Rb = 32'd2;
    #1;
    checks++; if (in_ready !== 1'b0) fail("bp_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) fail("bp_hold_valid", out_valid, 1'b1);
      checks++; if (out_opcode !== 4'hC) fail("bp_hold_opcode", out_opcode, 4'hC);
      checks++; if (out_rd !== 4'd4) fail("bp_hold_rd", out_rd, 4'd4);
      checks++; if (out_imm !== 32'h0000_1234) fail("bp_hold_imm", out_imm, 32'h0000_1234);
      checks++; if (in_ready !== 1'b0) fail("bp_hold_ready", in_ready, 1'b0);
      checks++; if (dut.pend !== 16'h0020) fail("bp_hold_pend", dut.pend, 16'h0020);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) fail("bp_release", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_opcode !== 4'h3) fail("bp_next_opcode", out_opcode, 4'h3);
    checks++; if (out_rd !== 4'd7) fail("bp_next_rd", out_rd, 4'd7);
    checks++; if (out_a !== 32'd1) fail("bp_next_a", out_a, 32'd1);
    checks++; if (out_b !== 32'd2) fail("bp_next_b", out_b, 32'd2);
    checks++; if (out_imm !== 32'd5) fail("bp_next_imm", out_imm, 32'd5);
    checks++; if (dut.pend !== 16'h00A0) fail("bp_next_pend", dut.pend, 16'h00A0);

    in_valid = 1'b1;
    in_instr = 32'h4600_0000;
    wb_valid = 1'b1;
    wb_rd    = 4'd6;
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    #1;
    checks++; if (out_rd !== 4'd6) fail("setwin_rd", out_rd, 4'd6);
    checks++; if (dut.pend !== 16'h00E0) fail("setwin_pend", dut.pend, 16'h00E0);

    wb_valid = 1'b1;
    wb_rd    = 4'd2;
    tick();
    wb_rd = 4'd5;
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (dut.pend !== 16'h00C0) fail("idle_wb_pend", dut.pend, 16'h00C0);
    checks++; if (out_valid !== 1'b0) fail("idle_wb_out_valid", out_valid, 1'b0);

    in_valid   = 1'b1;
    in_instr   = 32'h5222_8000;
    rf_data_Ra = 32'hA;
    rf_data_Rb = 32'hA;
    #1;
    checks++; if (in_ready !== 1'b1) fail("same_reg_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_a !== 32'hA) fail("same_reg_a", out_a, 32'hA);
    checks++; if (out_imm !== 32'hFFFF_8000) fail("same_reg_imm", out_imm, 32'hFFFF_8000);
    checks++; if (dut.pend !== 16'h00C4) fail("same_reg_pend", dut.pend, 16'h00C4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
